// File: rtl/wordcount_word_unpacker_if.sv
// Generic valid/ready stream with an end-of-transfer marker. It carries both the
// 512-bit read-master beats and the 128-bit words handed to the core.
interface wordcount_word_unpacker_if #(
  parameter int WIDTH = 512
) ();
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;
  logic             last;

  modport master (output valid, output data, output last, input  ready);
  modport slave  (input  valid, input  data, input  last, output ready);
endinterface

// File: rtl/wordcount_word_unpacker.sv
// Splits read-master beats into fixed-width words and emits exactly num_of_words
// of them, lowest slice first, then pulses done for the kick sequencer.
module wordcount_word_unpacker #(
  parameter int DATA_WIDTH = 512,
  parameter int WORD_WIDTH = 128
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            kick,
  input  logic [31:0]                     num_of_words,
  output logic                            busy,
  output logic                            done,
  output logic                            err_short,
  output logic [31:0]                     words_emitted,
  wordcount_word_unpacker_if.slave        s_axis,
  wordcount_word_unpacker_if.master       m_word
);

  localparam int WORDS_PER_BEAT = DATA_WIDTH / WORD_WIDTH;
  localparam int IDX_W          = (WORDS_PER_BEAT > 1) ? $clog2(WORDS_PER_BEAT) : 1;

  typedef enum logic [1:0] {IDLE, FETCH, EMIT, FINISH} state_t;

  state_t                                    state, next_state;
  logic [31:0]                               remaining;
  logic [WORDS_PER_BEAT-1:0][WORD_WIDTH-1:0] beat;
  logic [IDX_W-1:0]                          idx;
  logic                                      word_hs;
  logic                                      last_slice;
  logic                                      beat_acc;
  logic [31:0]                               rem_before_beat;

  // When a beat lands on the last-slice handshake, that handshake's word is
  // already gone, so the new beat is judged against the decremented count.
  always_comb begin
    word_hs         = (state == EMIT) && m_word.ready;
    last_slice      = (idx == IDX_W'(WORDS_PER_BEAT - 1));
    beat_acc        = s_axis.valid && s_axis.ready;
    rem_before_beat = word_hs ? remaining - 32'd1 : remaining;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every register sees pre-edge values.
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    // NOTE: default assignment first, so no path leaves next_state unassigned (no latch).
    next_state = state;
    unique case (state)
      IDLE:   if (kick) next_state = (num_of_words == 32'd0) ? FINISH : FETCH;
      FETCH:  if (beat_acc) next_state = EMIT;
      EMIT: begin
        if (word_hs) begin
          if (remaining == 32'd1)          next_state = FINISH;
          else if (last_slice && !beat_acc) next_state = FETCH;
        end
      end
      FINISH: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy          = 1'b0;
    done          = 1'b0;
    s_axis.ready  = 1'b0;
    m_word.valid  = 1'b0;
    m_word.last   = 1'b0;
    unique case (state)
      FETCH: begin
        busy         = 1'b1;
        s_axis.ready = 1'b1;
      end
      EMIT: begin
        busy         = 1'b1;
        m_word.valid = 1'b1;
        m_word.last  = (remaining == 32'd1);
        // Refill in the same cycle the last slice leaves, so words stream without a bubble.
        s_axis.ready = word_hs && last_slice && (remaining > 32'd1);
      end
      FINISH:  done = 1'b1;
      default: ;
    endcase
  end

  assign m_word.data = beat[idx];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      // NOTE: the beat register is cleared on reset too, so no stale data survives an abandoned run.
      remaining     <= '0;
      words_emitted <= '0;
      err_short     <= 1'b0;
      beat          <= '0;
      idx           <= '0;
    end else begin
      if (state == IDLE && kick) begin
        remaining     <= num_of_words;
        words_emitted <= '0;
        err_short     <= 1'b0;
      end
      if (word_hs) begin
        remaining     <= remaining - 32'd1;
        words_emitted <= words_emitted + 32'd1;
        idx           <= idx + 1'b1;
      end
      if (beat_acc) begin
        beat <= s_axis.data;
        idx  <= '0;
        if (s_axis.last && (rem_before_beat > 32'(WORDS_PER_BEAT))) err_short <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_wordcount_word_unpacker.sv
// Randomized bench for wordcount_word_unpacker: expected words, last flags, beat
// counts, done timing and err_short are derived from the run parameters alone.
module tb_wordcount_word_unpacker;

  localparam int DATA_WIDTH = 512;
  localparam int WORD_WIDTH = 128;
  localparam int WPB        = DATA_WIDTH / WORD_WIDTH;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        kick;
  logic [31:0] num_of_words;
  logic        busy;
  logic        done;
  logic        err_short;
  logic [31:0] words_emitted;

  wordcount_word_unpacker_if #(.WIDTH(DATA_WIDTH)) s_axis ();
  wordcount_word_unpacker_if #(.WIDTH(WORD_WIDTH)) m_word ();

  wordcount_word_unpacker #(
    .DATA_WIDTH (DATA_WIDTH),
    .WORD_WIDTH (WORD_WIDTH)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .kick          (kick),
    .num_of_words  (num_of_words),
    .busy          (busy),
    .done          (done),
    .err_short     (err_short),
    .words_emitted (words_emitted),
    .s_axis        (s_axis),
    .m_word        (m_word)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [DATA_WIDTH-1:0] got,
                       input logic [DATA_WIDTH-1:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One complete run. Inputs change 1 ns after each rising edge, outputs are
  // observed 4 ns after it; cycle 0 carries the kick.
  task automatic run(input int num, input int nbeats, input int tlast_beat,
                     input bit rand_ready, input int rst_at);
    logic [DATA_WIDTH-1:0] beats[$];
    logic [DATA_WIDTH-1:0] b;
    logic [WORD_WIDTH-1:0] exp_w;
    logic [WORD_WIDTH-1:0] prev_data = '0;
    bit prev_stall = 1'b0;
    bit prev_last  = 1'b0;
    bit s_hs, m_hs, exp_err;
    int need, budget;
    int bi = 0, wi = 0;
    int first_hs = -1, last_hs = -1;
    int done_cnt = 0, done_cyc = -1;
    int viol = 0, rst_cyc = -1, err_cyc = -1;

    need    = (num + WPB - 1) / WPB;
    exp_err = (tlast_beat < need) && ((num - WPB * tlast_beat) > WPB);
    for (int i = 0; i < nbeats; i++) begin
      for (int k = 0; k < DATA_WIDTH / 32; k++) b[32*k +: 32] = $urandom;
      beats.push_back(b);
    end
    budget = 4 * num + 40;

    for (int cyc = 0; cyc < budget; cyc++) begin
      @(posedge clk);
      #1;
      // A second kick mid-run with a different count must have no effect.
      kick          = (cyc == 0) || (cyc == 3 && num > 0);
      num_of_words  = (cyc == 0) ? 32'(num) : 32'd7;
      m_word.ready  = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      s_axis.valid  = (bi < nbeats);
      s_axis.data   = (bi < nbeats) ? beats[bi] : '0;
      s_axis.last   = (bi == tlast_beat);
      reset_n       = 1'b1;
      if (rst_at >= 0 && rst_cyc < 0 && wi == rst_at) begin
        reset_n      = 1'b0;
        m_word.ready = 1'b0;
        s_axis.valid = 1'b0;
        rst_cyc      = cyc;
      end
      #3;
      if (rst_cyc >= 0 && cyc == rst_cyc + 1)
        check("reset_mid_run_outputs",
              {busy, done, err_short, s_axis.ready, m_word.valid, m_word.last, words_emitted}, '0);

      s_hs = s_axis.valid && s_axis.ready;
      m_hs = m_word.valid && m_word.ready;
      if (s_hs) begin
        if (bi == tlast_beat) err_cyc = cyc + 1;
        bi++;
      end
      if (m_hs) begin
        if (wi < num) begin
          b     = beats[wi / WPB];
          exp_w = b[(wi % WPB) * WORD_WIDTH +: WORD_WIDTH];
          check("word_data", m_word.data, exp_w);
          check("word_last", m_word.last, (wi == num - 1));
        end else begin
          viol++;
        end
        if (first_hs < 0) first_hs = cyc;
        last_hs = cyc;
        wi++;
      end

      if (rst_cyc < 0 && prev_stall &&
          (!m_word.valid || m_word.data !== prev_data || m_word.last !== prev_last)) viol++;
      prev_stall = m_word.valid && !m_word.ready;
      prev_data  = m_word.data;
      prev_last  = m_word.last;
      if (busy && done) viol++;
      if (cyc >= 1 && num > 0 && done_cnt == 0 && !done && rst_cyc < 0 && !busy) viol++;
      if (cyc == 1) check("err_cleared_by_kick", err_short, 1'b0);
      if (cyc == err_cyc) check("err_short_after_tlast_beat", err_short, exp_err);
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (done_cyc >= 0 && cyc == done_cyc + 2) break;
      if (rst_cyc >= 0 && cyc == rst_cyc + 8) break;
    end

    if (rst_cyc >= 0) begin
      check("no_done_after_reset", done_cnt, 0);
      check("reset_mid_run_invariants", viol, 0);
      return;
    end
    check("done_count", done_cnt, 1);
    check("done_timing", done_cyc, (num == 0) ? 1 : last_hs + 1);
    check("words_seen", wi, num);
    check("beats_taken", bi, need);
    check("words_emitted", words_emitted, 32'(num));
    check("err_short_final", err_short, exp_err);
    check("invariants", viol, 0);
    if (!rand_ready && num > 0) begin
      check("first_word_latency", first_hs, 2);
      check("no_bubbles", last_hs - first_hs, num - 1);
    end
  endtask

  initial begin
    reset_n      = 1'b0;
    kick         = 1'b0;
    num_of_words = '0;
    s_axis.valid = 1'b0;
    s_axis.data  = '0;
    s_axis.last  = 1'b0;
    m_word.ready = 1'b0;
    repeat (2) @(posedge clk);
    #4;
    check("reset_state",
          {busy, done, err_short, s_axis.ready, m_word.valid, m_word.last, words_emitted}, '0);

    run(128, 32, 31, 1'b0, -1);  // full streaming run
    run(6,   3,  2,  1'b0, -1);  // partial beat, third beat never taken
    run(0,   2,  1,  1'b0, -1);  // empty run
    run(8,   2,  1,  1'b1, -1);  // stalled consumer
    run(12,  3,  1,  1'b0, -1);  // early tlast flags err_short
    run(5,   2,  1,  1'b0, -1);  // next kick clears it
    run(128, 32, 31, 1'b0, 50);  // reset abandons the run
    run(128, 32, 31, 1'b0, -1);  // fresh run after reset
    for (int r = 0; r < 6; r++) begin
      int n, nb;
      n  = $urandom_range(1, 40);
      nb = (n + WPB - 1) / WPB + 1;
      run(n, nb, $urandom_range(0, nb - 1), 1'($urandom_range(0, 1)), -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
